dac_spi_rx: RTL and testbench
=============================

// Module: dac_spi_rx
// PURPOSE
//   SPI slave that receives the galvo DAC stream (csn/sclk/mosi/latchn) and decodes it into
//   per-channel 12-bit codes, emulating an MCP4922-style dual DAC. Used for on-board loopback
//   self-test of the projector's DAC transmitter and as a capture point for a second FPGA.
//   SPI pins are oversampled in the clk domain. Decoded X/Y codes feed the debug LEDs and checkers.
// PARAMETERS
//   WORD_BITS    16  bits per SPI frame, MSB first
//   DATA_BITS    12  DAC code width, frame bits [11:0]
//   SYNC_STAGES  2   synchronizer flops per SPI input (>=2)
//   CNT_W        16  width of statistics counters
// PORTS
//   clk          in   1          system clock (50 MHz); only clock
//   reset        in   1          asynchronous, active-low reset
//   dac_csn      in   1          SPI chip select, active low
//   dac_sclk     in   1          SPI clock; mosi sampled on rising edge
//   dac_mosi     in   1          SPI data
//   dac_latchn   in   1          LDAC; falling edge transfers input regs to outputs
//   ch_a_code    out  DATA_BITS  channel A (X) output code
//   ch_b_code    out  DATA_BITS  channel B (Y) output code
//   ch_a_on      out  1          channel A active (SHDN bit of last latched word)
//   ch_b_on      out  1          channel B active
//   out_valid    out  1          1-cycle pulse when outputs update
//   frame_err    out  1          1-cycle pulse on bad frame length
//   busy         out  1          high while a frame is in progress (state SHIFT)
//   good_cnt     out  CNT_W      committed frames (stats feature)
//   err_cnt      out  CNT_W      errored frames (stats feature)
// BEHAVIOUR
//   - Reset: all outputs, input regs, bit counter and counters = 0; state IDLE.
//   - Inputs pass SYNC_STAGES flops. Edges come from synced value vs. one-cycle-delayed value.
//     Minimum supported: sclk high/low each >= 2 clk periods, i.e. f_sclk <= clk/4.
//   - Frame word: [15]=A/B (0=A,1=B), [14]=BUF, [13]=GA, [12]=SHDN (1=active), [11:0]=code.
//   - FSM IDLE: csn fall -> SHIFT; bit counter <= 0, shift reg <= 0.
//   - FSM SHIFT: each sclk rise: shift reg <= {shift[14:0], mosi}; counter increments and saturates at WORD_BITS+1.
//   - SHIFT, csn rise -> IDLE:
//       - counter==WORD_BITS: commit. Selected channel's input reg <= {SHDN, code}; good_cnt++.
//       - otherwise: discard; frame_err pulses the next cycle; err_cnt++.
//   - sclk edges while in IDLE are ignored. BUF and GA are decoded but not stored.
//   - latchn fall (synced), any state: ch_*_code/ch_*_on <= input regs; out_valid pulses the same cycle the regs load.
//   - Commit and latchn fall in the same cycle: the commit is bypassed into the latched outputs, so the new word is visible.
//   - Latency: csn rise to input reg = SYNC_STAGES+1 clk. latchn fall to outputs = SYNC_STAGES+1 clk.
//   - Counters wrap modulo 2^CNT_W.
//   - Reset asserted mid-frame aborts the frame without frame_err. A later csn low is treated as a new frame only after a fresh csn fall.
// CONFIGURATION
//   DAC_RX_STATS_EN defined: good_cnt and err_cnt count as described.
//   DAC_RX_STATS_EN undefined: counters are not built; good_cnt = err_cnt = 0. All other behaviour is identical.
// STRUCTURE
//   Package dac_rx_pkg holds:
//     - field positions (AB_BIT=15, BUF_BIT=14, GA_BIT=13, SHDN_BIT=12);
//     - the FSM state encoding (IDLE=0, SHIFT=1);
//     - WORD_BITS/DATA_BITS defaults.
//   Sub-module sync_edge: SYNC_STAGES synchronizer plus rise/fall detect.
//     - One instance each for csn, sclk and latchn.
//     - mosi uses the synchronizer only.
//   The FSM, shift register and output registers stay in dac_spi_rx.
// TESTING
//   1. Send 0x1ABC (A, active, code 0xABC), then pulse latchn -> ch_a_code=0xABC, ch_a_on=1, one out_valid pulse, good_cnt=1.
//   2. Send 0x9123 (B, active) then 0x0456 (A, shutdown), then latchn -> ch_b_code=0x123, ch_b_on=1, ch_a_code=0x456, ch_a_on=0.
//   3. csn rises after 15 bits, and separately after 17 bits -> frame_err pulses each time; err_cnt=2; input regs unchanged.
//   4. latchn fall in the same clk as commit of 0x1FFF -> outputs show 0xFFF with a single out_valid.
//   5. Toggle sclk with csn high, then reset asserted mid-frame after 8 bits -> no commit, no frame_err, outputs 0.
//   6. Rebuild without DAC_RX_STATS_EN and rerun 1-3 -> identical codes and pulses; good_cnt = err_cnt = 0.

Source files
------------

// File: rtl/dac_spi_rx_pkg.sv
// ============================================================================
// Module  : dac_rx_pkg
// Purpose : Shared frame field positions, FSM encoding and size defaults for
//           the MCP4922-style DAC stream receiver.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dac_rx_pkg;

    localparam int DEF_WORD_BITS = 16;
    localparam int DEF_DATA_BITS = 12;

    localparam int AB_BIT   = 15;
    localparam int BUF_BIT  = 14;
    localparam int GA_BIT   = 13;
    localparam int SHDN_BIT = 12;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/dac_spi_rx_if.sv
// ============================================================================
// Module  : dac_spi_rx_if
// Purpose : DAC SPI pins plus decoded channel outputs; master drives the SPI
//           side, slave (the receiver) drives the decoded side.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface dac_spi_rx_if
    import dac_rx_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int CNT_W     = 16
);
    logic                 dac_csn;
    logic                 dac_sclk;
    logic                 dac_mosi;
    logic                 dac_latchn;
    logic [DATA_BITS-1:0] ch_a_code;
    logic [DATA_BITS-1:0] ch_b_code;
    logic                 ch_a_on;
    logic                 ch_b_on;
    logic                 out_valid;
    logic                 frame_err;
    logic                 busy;
    logic [CNT_W-1:0]     good_cnt;
    logic [CNT_W-1:0]     err_cnt;

    modport master (
        output dac_csn, dac_sclk, dac_mosi, dac_latchn,
        input  ch_a_code, ch_b_code, ch_a_on, ch_b_on,
        input  out_valid, frame_err, busy, good_cnt, err_cnt
    );

    modport slave (
        input  dac_csn, dac_sclk, dac_mosi, dac_latchn,
        output ch_a_code, ch_b_code, ch_a_on, ch_b_on,
        output out_valid, frame_err, busy, good_cnt, err_cnt
    );
endinterface

`default_nettype wire

// File: rtl/dac_spi_rx_sync_edge.sv
// ============================================================================
// Module  : sync_edge
// Purpose : Multi-flop synchronizer for one asynchronous pin with rise/fall
//           detection against the one-cycle-delayed synchronized value.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_edge #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic d_i,
    output logic      q_o,
    output logic      rise_o,
    output logic      fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;
endmodule

`default_nettype wire

// File: rtl/dac_spi_rx.sv
// ============================================================================
// Module  : dac_spi_rx
// Purpose : Oversampled SPI slave decoding a dual-channel DAC stream into
//           latched 12-bit codes. Optional statistics: DAC_RX_STATS_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dac_spi_rx
    import dac_rx_pkg::*;
#(
    parameter int WORD_BITS   = DEF_WORD_BITS,
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  wire logic   clk,
    input  wire logic   reset,
    dac_spi_rx_if.slave bus
);
    localparam int            CW     = $clog2(WORD_BITS + 2);
    localparam logic [CW-1:0] C_FULL = CW'(WORD_BITS);
    localparam logic [CW-1:0] C_SAT  = CW'(WORD_BITS + 1);

    logic csn_s,    csn_rise,    csn_fall;
    logic sclk_s,   sclk_rise,   sclk_fall;
    logic latchn_s, latchn_rise, latchn_fall;
    logic mosi_s,   mosi_rise,   mosi_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_csn (
        .clk(clk), .rst_n(reset), .d_i(bus.dac_csn),
        .q_o(csn_s), .rise_o(csn_rise), .fall_o(csn_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(reset), .d_i(bus.dac_sclk),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_latchn (
        .clk(clk), .rst_n(reset), .d_i(bus.dac_latchn),
        .q_o(latchn_s), .rise_o(latchn_rise), .fall_o(latchn_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst_n(reset), .d_i(bus.dac_mosi),
        .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    state_e               state_q;
    logic [CW-1:0]        bitcnt_q;
    logic [WORD_BITS-1:0] shift_q;
    logic [DATA_BITS:0]   in_a_q, in_a_d;
    logic [DATA_BITS:0]   in_b_q, in_b_d;
    logic [DATA_BITS-1:0] a_code_q, b_code_q;
    logic                 a_on_q, b_on_q;
    logic                 valid_q, ferr_q;

    logic                 commit, abort;
    logic [DATA_BITS:0]   word_val;
    logic                 frame_buf, frame_ga;

    assign frame_buf = shift_q[BUF_BIT];
    assign frame_ga  = shift_q[GA_BIT];

    // Input regs hold {SHDN, code}; the _d values double as the latch bypass.
    always_comb begin
        word_val = {shift_q[SHDN_BIT], shift_q[DATA_BITS-1:0]};
        commit   = (state_q == SHIFT) && csn_rise && (bitcnt_q == C_FULL);
        abort    = (state_q == SHIFT) && csn_rise && (bitcnt_q != C_FULL);
        in_a_d   = in_a_q;
        in_b_d   = in_b_q;
        if (commit) begin
            if (shift_q[AB_BIT]) begin
                in_b_d = word_val;
            end else begin
                in_a_d = word_val;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            in_a_q   <= '0;
            in_b_q   <= '0;
            a_code_q <= '0;
            b_code_q <= '0;
            a_on_q   <= 1'b0;
            b_on_q   <= 1'b0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            valid_q <= latchn_fall;
            ferr_q  <= abort;
            in_a_q  <= in_a_d;
            in_b_q  <= in_b_d;
            if (latchn_fall) begin
                {a_on_q, a_code_q} <= in_a_d;
                {b_on_q, b_code_q} <= in_b_d;
            end
            case (state_q)
                IDLE: begin
                    if (csn_fall) begin
                        state_q  <= SHIFT;
                        bitcnt_q <= '0;
                        shift_q  <= '0;
                    end
                end
                SHIFT: begin
                    if (csn_rise) begin
                        state_q <= IDLE;
                    end else if (sclk_rise) begin
                        shift_q <= {shift_q[WORD_BITS-2:0], mosi_s};
                        if (bitcnt_q != C_SAT) begin
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DAC_RX_STATS_EN
    logic [CNT_W-1:0] good_q, err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            good_q <= '0;
            err_q  <= '0;
        end else begin
            if (commit) good_q <= good_q + CNT_W'(1);
            if (abort)  err_q  <= err_q  + CNT_W'(1);
        end
    end

    assign bus.good_cnt = good_q;
    assign bus.err_cnt  = err_q;
`else
    assign bus.good_cnt = '0;
    assign bus.err_cnt  = '0;
`endif

    assign bus.ch_a_code = a_code_q;
    assign bus.ch_b_code = b_code_q;
    assign bus.ch_a_on   = a_on_q;
    assign bus.ch_b_on   = b_on_q;
    assign bus.out_valid = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q == SHIFT);

    logic unused_sigs;
    assign unused_sigs = &{1'b0, csn_s, sclk_s, sclk_fall, latchn_s, latchn_rise,
                           mosi_rise, mosi_fall, frame_buf, frame_ga};
endmodule

`default_nettype wire

// File: tb/tb_dac_spi_rx.sv
// ============================================================================
// Module  : tb_dac_spi_rx
// Purpose : Directed plus randomized frames against a behavioural DAC model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dac_spi_rx;
`ifdef DAC_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    dac_spi_rx_if #(.DATA_BITS(12), .CNT_W(16)) bus ();

    dac_spi_rx #(
        .WORD_BITS(16), .DATA_BITS(12), .SYNC_STAGES(2), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(rst_n), .bus(bus)
    );

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_valid = 0;
    int n_ferr  = 0;

    // Model: what a real MCP4922 would hold, indexed 0 = A, 1 = B.
    logic [11:0] m_in_code  [2];
    logic        m_in_on    [2];
    logic [11:0] m_out_code [2];
    logic        m_out_on   [2];
    int          m_good;
    int          m_err;

    always @(negedge clk) begin
        if (bus.out_valid) n_valid++;
        if (bus.frame_err) n_ferr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_in_code[k]  = '0;
            m_in_on[k]    = 1'b0;
            m_out_code[k] = '0;
            m_out_on[k]   = 1'b0;
        end
        m_good = 0;
        m_err  = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".a_code"}, 32'(bus.ch_a_code), 32'(m_out_code[0]));
        check({tag, ".a_on"},   32'(bus.ch_a_on),   32'(m_out_on[0]));
        check({tag, ".b_code"}, 32'(bus.ch_b_code), 32'(m_out_code[1]));
        check({tag, ".b_on"},   32'(bus.ch_b_on),   32'(m_out_on[1]));
        check({tag, ".good"},   32'(bus.good_cnt),  STATS ? 32'(m_good % 65536) : 32'd0);
        check({tag, ".err"},    32'(bus.err_cnt),   STATS ? 32'(m_err % 65536)  : 32'd0);
    endtask

    // Called right after latchn was driven low at a falling clk edge.
    task automatic latch_check(input string tag);
        int v0;
        v0 = n_valid;
        for (int k = 0; k < 2; k++) begin
            m_out_code[k] = m_in_code[k];
            m_out_on[k]   = m_in_on[k];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({tag, ".early"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check_outputs(tag);
        bus.dac_latchn = 1'b1;
        wait_clk(6);
        check({tag, ".pulses"}, 32'(n_valid - v0), 32'd1);
    endtask

    task automatic latch(input string tag);
        bus.dac_latchn = 1'b0;
        latch_check(tag);
        wait_clk(2);
    endtask

    task automatic frame(input int nbits, input logic [16:0] w, input bit with_latch,
                         input string tag);
        int f0;
        int ch;
        f0 = n_ferr;
        bus.dac_csn = 1'b0;
        wait_clk(4);
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.dac_mosi = w[i];
            wait_clk(3);
            bus.dac_sclk = 1'b1;
            wait_clk(3);
            bus.dac_sclk = 1'b0;
        end
        wait_clk(3);
        if (nbits == 16) begin
            ch = int'(w[15]);
            m_in_code[ch] = w[11:0];
            m_in_on[ch]   = w[12];
            m_good++;
        end else begin
            m_err++;
        end
        bus.dac_csn = 1'b1;
        if (with_latch) begin
            bus.dac_latchn = 1'b0;
            latch_check(tag);
        end
        wait_clk(8);
        check({tag, ".idle"}, 32'(bus.busy), 32'd0);
        check({tag, ".ferr"}, 32'(n_ferr - f0), 32'(nbits != 16));
        check_outputs(tag);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int f0;
        int v0;
        int nb;
        int kind;
        logic [16:0] w;

        bus.dac_csn    = 1'b1;
        bus.dac_sclk   = 1'b0;
        bus.dac_mosi   = 1'b0;
        bus.dac_latchn = 1'b1;
        model_reset();
        wait_clk(5);
        check_outputs("reset");
        check("reset.busy",  32'(bus.busy),      32'd0);
        check("reset.valid", 32'(bus.out_valid), 32'd0);
        check("reset.ferr",  32'(bus.frame_err), 32'd0);
        rst_n = 1'b1;
        wait_clk(5);

        frame(16, 17'h01ABC, 1'b0, "t1");
        latch("t1l");

        frame(16, 17'h09123, 1'b0, "t2b");
        frame(16, 17'h00456, 1'b0, "t2a");
        latch("t2l");

        frame(15, 17'h01555, 1'b0, "t3s");
        frame(17, 17'h1F0F0, 1'b0, "t3l");
        latch("t3x");

        frame(16, 17'h01FFF, 1'b1, "t4");

        // sclk activity with csn high must be ignored
        f0 = n_ferr;
        for (int i = 0; i < 6; i++) begin
            bus.dac_mosi = 1'($urandom);
            wait_clk(3);
            bus.dac_sclk = 1'b1;
            wait_clk(3);
            bus.dac_sclk = 1'b0;
        end
        wait_clk(8);
        check("t5.idle", 32'(bus.busy), 32'd0);
        check_outputs("t5.noframe");

        // reset in the middle of a frame, csn stays low afterwards
        v0 = n_valid;
        bus.dac_csn = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 8; i++) begin
            bus.dac_mosi = 1'($urandom);
            wait_clk(3);
            bus.dac_sclk = 1'b1;
            wait_clk(3);
            bus.dac_sclk = 1'b0;
        end
        rst_n = 1'b0;
        model_reset();
        wait_clk(3);
        check_outputs("t5.inreset");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.dac_mosi = 1'($urandom);
            wait_clk(3);
            bus.dac_sclk = 1'b1;
            wait_clk(3);
            bus.dac_sclk = 1'b0;
        end
        check("t5.nobusy", 32'(bus.busy), 32'd0);
        wait_clk(3);
        bus.dac_csn = 1'b1;
        wait_clk(8);
        check("t5.ferr",  32'(n_ferr - f0),  32'd0);
        check("t5.valid", 32'(n_valid - v0), 32'd0);
        check_outputs("t5.after");
        latch("t5l");

        for (int it = 0; it < 30; it++) begin
            kind = int'($urandom_range(0, 9));
            nb   = (kind == 0) ? 15 : (kind == 1) ? 17 : 16;
            w    = 17'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                frame(nb, w, 1'b1, $sformatf("r%0d", it));
            end else begin
                frame(nb, w, 1'b0, $sformatf("r%0d", it));
                if ($urandom_range(0, 1) == 1) latch($sformatf("r%0dl", it));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
